branch_target_buffer: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters. It is the other end of the BTB install interface driven by the decode stage (`b_we`/`b_waddr`/`b_wtarget`). It also serves the IF stage with a same-cycle prediction (`taken`, target). Direction counters are trained by the execute stage when a branch resolves.

---
 rtl/branch_target_buffer_if.sv | 34 +++
 rtl/branch_target_buffer.sv | 108 ++++++++++
 tb/tb_branch_target_buffer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup, decode-install and execute-resolve signals of the branch target buffer.
// Optional BTB_PERF_EN adds the lookup/hit statistics outputs.
interface branch_target_buffer_if;
    logic [31:0] pc_i;
    logic        hit_o;
    logic        taken_o;
    logic [31:0] target_o;
    logic        b_we_i;
    logic [31:0] b_waddr_i;
    logic [31:0] b_wtarget_i;
    logic        ex_upd_i;
    logic [31:0] ex_pc_i;
    logic        ex_taken_i;
`ifdef BTB_PERF_EN
    logic [31:0] lookup_cnt_o;
    logic [31:0] hit_cnt_o;
`endif

    modport master (
        output pc_i, b_we_i, b_waddr_i, b_wtarget_i, ex_upd_i, ex_pc_i, ex_taken_i,
`ifdef BTB_PERF_EN
        input  lookup_cnt_o, hit_cnt_o,
`endif
        input  hit_o, taken_o, target_o
    );

    modport slave (
        input  pc_i, b_we_i, b_waddr_i, b_wtarget_i, ex_upd_i, ex_pc_i, ex_taken_i,
`ifdef BTB_PERF_EN
        output lookup_cnt_o, hit_cnt_o,
`endif
        output hit_o, taken_o, target_o
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters and same-cycle lookup.
// Optional macro BTB_PERF_EN adds lookup/hit statistics counters.
module branch_target_buffer #(
    parameter int unsigned INDEX_BITS = 7
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  rdy,
    branch_target_buffer_if.slave bus
);
    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] l_idx, w_idx, r_idx;
    logic [TAG_BITS-1:0]   l_tag, w_tag, r_tag;
    logic                  l_hit, w_hit, r_hit;
    logic                  install_en, install_miss, resolve_en;
    logic [1:0]            res_ctr, ctr_next;
    logic                  unused_low_bits;

    assign unused_low_bits = ^{bus.b_waddr_i[1:0], bus.ex_pc_i[1:0]};

    assign l_idx = bus.pc_i[INDEX_BITS+1:2];
    assign l_tag = bus.pc_i[31:INDEX_BITS+2];
    assign w_idx = bus.b_waddr_i[INDEX_BITS+1:2];
    assign w_tag = bus.b_waddr_i[31:INDEX_BITS+2];
    assign r_idx = bus.ex_pc_i[INDEX_BITS+1:2];
    assign r_tag = bus.ex_pc_i[31:INDEX_BITS+2];

    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign w_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    // Lookup reads registered state only; writes become visible next cycle.
    always_comb begin
        bus.hit_o    = l_hit;
        bus.taken_o  = l_hit && ctr_q[l_idx][1];
        bus.target_o = bus.pc_i + 32'd4;
        if (bus.taken_o) begin
            bus.target_o = target_q[l_idx];
        end
    end

    // A replacing install on the resolved index discards that resolve.
    assign install_en   = bus.b_we_i && rdy && !rst;
    assign install_miss = install_en && !w_hit;
    assign resolve_en   = bus.ex_upd_i && rdy && !rst && r_hit
                          && !(install_miss && (w_idx == r_idx));

    always_comb begin
        res_ctr  = ctr_q[r_idx];
        ctr_next = res_ctr;
        if (bus.ex_taken_i) begin
            if (res_ctr != 2'b11) begin
                ctr_next = res_ctr + 2'd1;
            end
        end else begin
            if (res_ctr != 2'b00) begin
                ctr_next = res_ctr - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (install_miss) begin
            valid_q[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (install_en) begin
            target_q[w_idx] <= bus.b_wtarget_i;
        end
        if (install_miss) begin
            tag_q[w_idx] <= w_tag;
            ctr_q[w_idx] <= 2'b01;
        end
        if (resolve_en) begin
            ctr_q[r_idx] <= ctr_next;
        end
    end

`ifdef BTB_PERF_EN
    logic [31:0] lookup_cnt_q, hit_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else if (rdy) begin
            lookup_cnt_q <= lookup_cnt_q + 32'd1;
            if (l_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
        end
    end

    assign bus.lookup_cnt_o = lookup_cnt_q;
    assign bus.hit_cnt_o    = hit_cnt_q;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed installs/resolves with hand-computed lookups.
module tb_branch_target_buffer;
    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic chk = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    branch_target_buffer_if bus();

    branch_target_buffer #(.INDEX_BITS(7)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation for every sampled lookup cycle.
    always @(negedge clk) begin
        if (chk) begin
            if (sb_q.size() == 0) begin
                compare("scoreboard_underrun", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                compare({e.name, ".hit"},    {31'd0, bus.hit_o},   {31'd0, e.hit});
                compare({e.name, ".taken"},  {31'd0, bus.taken_o}, {31'd0, e.taken});
                compare({e.name, ".target"}, bus.target_o,         e.target);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.b_we_i   = 1'b0;
        bus.ex_upd_i = 1'b0;
    endtask

    task automatic install(input logic [31:0] a, input logic [31:0] t);
        bus.b_we_i = 1'b1; bus.b_waddr_i = a; bus.b_wtarget_i = t;
        tick();
        idle();
    endtask

    task automatic resolve(input logic [31:0] a, input logic tk, input int n);
        for (int k = 0; k < n; k++) begin
            bus.ex_upd_i = 1'b1; bus.ex_pc_i = a; bus.ex_taken_i = tk;
            tick();
        end
        idle();
    endtask

    task automatic both(input logic [31:0] wa, input logic [31:0] wt,
                        input logic [31:0] ra, input logic tk);
        bus.b_we_i = 1'b1; bus.b_waddr_i = wa; bus.b_wtarget_i = wt;
        bus.ex_upd_i = 1'b1; bus.ex_pc_i = ra; bus.ex_taken_i = tk;
        tick();
        idle();
    endtask

    task automatic look(input string name, input logic [31:0] p,
                        input logic h, input logic tk, input logic [31:0] t);
        exp_t e;
        e.name = name; e.hit = h; e.taken = tk; e.target = t;
        bus.pc_i = p;
        sb_q.push_back(e);
        chk = 1'b1;
        tick();
        chk = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        bus.pc_i = 32'h0; bus.b_waddr_i = 32'h0; bus.b_wtarget_i = 32'h0;
        bus.ex_pc_i = 32'h0; bus.ex_taken_i = 1'b0;
        idle();
        tick(); tick();
        rst = 1'b0;

        look("reset", 32'h1000, 0, 0, 32'h1004);
        install(32'h1000, 32'h2000);
        look("install_weak", 32'h1000, 1, 0, 32'h1004);
        resolve(32'h1000, 1, 1);
        look("one_taken", 32'h1000, 1, 1, 32'h2000);
        resolve(32'h1000, 1, 4);
        look("sat_high", 32'h1000, 1, 1, 32'h2000);
        resolve(32'h1000, 0, 2);
        look("sat_then_down", 32'h1000, 1, 0, 32'h1004);
        resolve(32'h1000, 0, 4);
        resolve(32'h1000, 1, 1);
        look("no_underflow", 32'h1000, 1, 0, 32'h1004);
        resolve(32'h1000, 1, 1);
        look("climb_after_zero", 32'h1000, 1, 1, 32'h2000);
        install(32'h1000, 32'h2400);
        look("hit_retarget", 32'h1000, 1, 1, 32'h2400);
        look("low_bits_ignored", 32'h1002, 1, 1, 32'h2400);

        rdy = 1'b0;
        both(32'h1000, 32'h5000, 32'h1000, 0);
        install(32'h1004, 32'h5100);
        look("rdy_low_lookup", 32'h1000, 1, 1, 32'h2400);
        rdy = 1'b1;
        look("rdy_low_no_update", 32'h1000, 1, 1, 32'h2400);
        look("rdy_low_no_install", 32'h1004, 0, 0, 32'h1008);

        install(32'h1200, 32'h6000);
        look("alias_old_miss", 32'h1000, 0, 0, 32'h1004);
        look("alias_new_weak", 32'h1200, 1, 0, 32'h1204);
        resolve(32'h1000, 1, 1);
        look("alias_resolve_ignored", 32'h1200, 1, 0, 32'h1204);
        resolve(32'h1200, 1, 1);
        look("alias_resolve_hit", 32'h1200, 1, 1, 32'h6000);

        install(32'h3200, 32'h7000);
        resolve(32'h3200, 1, 2);
        look("prep_strong", 32'h3200, 1, 1, 32'h7000);
        both(32'h3000, 32'h8000, 32'h3000, 1);
        look("miss_install_wins", 32'h3000, 1, 0, 32'h3004);
        look("old_tag_gone", 32'h3200, 0, 0, 32'h3204);
        both(32'h3000, 32'h8800, 32'h3000, 1);
        look("hit_install_and_resolve", 32'h3000, 1, 1, 32'h8800);
        both(32'h1004, 32'h9000, 32'h3000, 0);
        look("diff_index_resolve", 32'h3000, 1, 0, 32'h3004);
        look("diff_index_install", 32'h1004, 1, 0, 32'h1008);
        resolve(32'h1004, 1, 1);
        look("idx1_taken", 32'h1004, 1, 1, 32'h9000);

        install(32'h01FC, 32'hA000);
        resolve(32'h01FC, 1, 1);
        look("top_index", 32'h01FC, 1, 1, 32'hA000);
        install(32'hFFFFFFFC, 32'h0040);
        resolve(32'hFFFFFFFC, 1, 1);
        look("top_tag", 32'hFFFFFFFC, 1, 1, 32'h0040);

        rst = 1'b1;
        both(32'h2000, 32'hB000, 32'h3000, 1);
        rst = 1'b0;
        look("rst_clears_a", 32'h3000, 0, 0, 32'h3004);
        look("rst_clears_b", 32'h1004, 0, 0, 32'h1008);
        look("rst_overrides_install", 32'h2000, 0, 0, 32'h2004);
        look("rst_wrap_pc", 32'hFFFFFFFC, 0, 0, 32'h0000_0000);

`ifdef BTB_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compare("perf_reset_lookups", bus.lookup_cnt_o, 32'd0);
        compare("perf_reset_hits", bus.hit_cnt_o, 32'd0);
        bus.pc_i = 32'h1100;
        install(32'h1000, 32'hC000);
        install(32'h1004, 32'hC100);
        for (int i = 0; i < 10; i++) begin
            bus.pc_i = (i < 4) ? ((i % 2 == 0) ? 32'h1000 : 32'h1004) : 32'h1100;
            tick();
        end
        rdy = 1'b0;
        bus.pc_i = 32'h1000;
        tick();
        rdy = 1'b1;
        compare("perf_lookups", bus.lookup_cnt_o, 32'd12);
        compare("perf_hits", bus.hit_cnt_o, 32'd4);
`endif

        tick();
        compare("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
